execute_cycle: RTL and testbench
================================

Name: execute_cycle

Overview:
- Execute stage of the 5-stage RISC-V pipeline. Sits directly downstream of decode_cycle and consumes its E-stage outputs.
- Performs operand forwarding, ALU operation, branch resolution and branch-target computation.
- Registers results into the E/M pipeline register that feeds memory_cycle.
- Branch decision (PCSrcE/PCTargetE) is combinational back to fetch.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register-index width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- RegWriteE  in  1  register-write control from decode
- ALUSrcE  in  1  0 = SrcB is forwarded RD2; 1 = SrcB is Imm_Ext_E
- MemWriteE  in  1  store enable
- ResultSrcE  in  1  0 = ALU result; 1 = memory data at writeback
- BranchE  in  1  beq instruction in E
- ALUControlE  in  3  ALU op
- RD1_E, RD2_E  in  XLEN  register-file read data
- Imm_Ext_E  in  XLEN  sign-extended immediate
- RD_E  in  5  destination register
- PCE, PCPlus4E  in  XLEN  PC of the instruction and PC+4
- ForwardA_E, ForwardB_E  in  2  forwarding selects from the hazard unit
- ResultW  in  XLEN  writeback-stage result
- PCSrcE  out  1  branch taken (combinational)
- PCTargetE  out  XLEN  branch target (combinational)
- RegWriteM, MemWriteM, ResultSrcM  out  1  registered controls
- RD_M  out  5  registered destination register
- ALUResultM  out  XLEN  registered ALU result
- WriteDataM  out  XLEN  registered store data
- PCPlus4M  out  XLEN  registered PC+4

Behaviour:
- Forward mux A (same rule for B):
  - 00 → RD1_E
  - 01 → ResultW
  - 10 → ALUResultM (the internal registered value)
  - 11 → treated as 00
- SrcB = ALUSrcE ? Imm_Ext_E : forwarded B.
- WriteDataM captures forwarded B, never the immediate.
- ALU ops; all arithmetic is modulo 2^XLEN with carry discarded:
  - 000 add
  - 001 sub
  - 010 and
  - 011 or
  - 101 slt (signed compare, result 0 or 1, zero-extended)
  - any other code → result 0
- Zero flag = (ALU result == 0).
- PCSrcE = BranchE & Zero.
- PCTargetE = PCE + Imm_Ext_E, modulo 2^XLEN. Valid in the same cycle with zero latency.
- E/M register:
  - Captures all M outputs on every posedge clk.
  - Latency is 1 cycle; no stall or flush inputs (the hazard unit flushes upstream).
- Reset:
  - While rst is high, all M outputs are 0 immediately, without waiting for a clock edge.
  - Deassertion takes effect at the next posedge.
  - Reset asserted mid-operation discards the in-flight instruction.
- PCSrcE/PCTargetE are not reset-gated; they follow the inputs combinationally.
- Forwarding from ALUResultM during reset yields 0.

Optional Feature:
- Macro: EXEC_EXT_ALU_EN.
- When defined, additional ALU ops are decoded:
  - 100 xor
  - 110 sll, shift amount = SrcB[4:0]
  - 111 srl (logical), shift amount = SrcB[4:0]
- When undefined, codes 100/110/111 produce 0 and Zero=1.

Decomposition:
- Package exec_pkg holds:
  - ALU op localparams (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, plus ALU_XOR, ALU_SLL, ALU_SRL)
  - forward-select localparams (FWD_RF=00, FWD_WB=01, FWD_MEM=10)
- One sub-module: alu (operands A/B, ALUControl → result, Zero). Purely combinational, instantiated once.
- Forward muxes, adder and pipeline register stay in execute_cycle.

Test Plan:
- Async reset: rst=1 between clock edges → all M outputs read 0 within the same timestep. Hold for 2 cycles, then rst=0 → first instruction captured at the next posedge.
- R-type add: RD1_E=5, RD2_E=7, ALUSrcE=0, ALUControlE=000, RD_E=1, RegWriteE=1, forwards=00 → after one posedge ALUResultM=12, RD_M=1, RegWriteM=1, MemWriteM=0.
- beq taken: RD1_E=RD2_E=0xAABBCCDD, ALUControlE=001, BranchE=1, PCE=0xC, Imm_Ext_E=0x10 → same cycle PCSrcE=1, PCTargetE=0x1C. With RD2_E=0 → PCSrcE=0.
- Forwarding: cycle 1 add producing ALUResultM=0x20. Cycle 2: ForwardA_E=01 with ResultW=0x10, ForwardB_E=10, add → ALUResultM=0x30.
- Store: MemWriteE=1, ALUSrcE=1, RD1_E=0x100, Imm_Ext_E=0xC, RD2_E=0xDEADBEEF → ALUResultM=0x10C, WriteDataM=0xDEADBEEF, MemWriteM=1.
- slt signed plus option: RD1_E=0xFFFFFFFF, RD2_E=1, op 101 → ALUResultM=1.
  - With EXEC_EXT_ALU_EN: op 110, RD1_E=1, RD2_E=4 → 0x10.
  - Without the macro: op 110 → 0.

Source files
------------

// File: rtl/exec_pkg.sv
// ----------------------------------------------------------------------------
// exec_pkg
// Shared constants for the execute stage: the ALU operation encodings and the
// operand-forwarding select encodings driven by the hazard unit.
// No ports (package only).
// ----------------------------------------------------------------------------
package exec_pkg;

  // ALU operation codes (ALUControlE)
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  // Forwarding selects (ForwardA_E / ForwardB_E); 2'b11 behaves as FWD_RF
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/execute_cycle_alu.sv
// ----------------------------------------------------------------------------
// alu
// Purely combinational ALU for the execute stage. All arithmetic wraps modulo
// 2^XLEN; undecoded operation codes produce 0 (and therefore zero = 1).
// Optional feature macro: EXEC_EXT_ALU_EN adds xor, sll and srl.
//
// Ports:
//   a, b         in  XLEN  operands (after forwarding / immediate select)
//   alu_control  in  3     operation code (see exec_pkg)
//   result       out XLEN  operation result
//   zero         out 1     result == 0
// ----------------------------------------------------------------------------
module alu
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      alu_control,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;

  assign a_s = a;
  assign b_s = b;

  always_comb begin
    result = '0;
    case (alu_control)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, (a_s < b_s)};
`ifdef EXEC_EXT_ALU_EN
      ALU_XOR: result = a ^ b;
      ALU_SLL: result = a << b[4:0];
      ALU_SRL: result = a >> b[4:0];
`endif
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/execute_cycle.sv
// ----------------------------------------------------------------------------
// execute_cycle
// Execute stage of the 5-stage RISC-V pipeline: operand forwarding, ALU,
// beq resolution and branch-target add, followed by the E/M pipeline register.
// PCSrcE / PCTargetE are combinational back to fetch and not reset-gated.
// Optional feature macro: EXEC_EXT_ALU_EN (extended ALU ops, see alu).
//
// Ports:
//   clk, rst                       clock, async active-high reset
//   RegWriteE, MemWriteE,
//   ResultSrcE, BranchE, ALUSrcE   decode controls
//   ALUControlE [2:0]              ALU op
//   RD1_E, RD2_E, Imm_Ext_E        operands / immediate
//   RD_E [REG_ADDR_W-1:0]          destination register
//   PCE, PCPlus4E                  PC and PC+4 of the instruction
//   ForwardA_E, ForwardB_E [1:0]   forwarding selects
//   ResultW                        writeback result for forwarding
//   PCSrcE, PCTargetE              branch taken / target (combinational)
//   RegWriteM, MemWriteM,
//   ResultSrcM, RD_M, ALUResultM,
//   WriteDataM, PCPlus4M           registered E/M outputs
// ----------------------------------------------------------------------------
module execute_cycle
  import exec_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteE,
  input  logic                  ALUSrcE,
  input  logic                  MemWriteE,
  input  logic                  ResultSrcE,
  input  logic                  BranchE,
  input  logic [2:0]            ALUControlE,
  input  logic [XLEN-1:0]       RD1_E,
  input  logic [XLEN-1:0]       RD2_E,
  input  logic [XLEN-1:0]       Imm_Ext_E,
  input  logic [REG_ADDR_W-1:0] RD_E,
  input  logic [XLEN-1:0]       PCE,
  input  logic [XLEN-1:0]       PCPlus4E,
  input  logic [1:0]            ForwardA_E,
  input  logic [1:0]            ForwardB_E,
  input  logic [XLEN-1:0]       ResultW,
  output logic                  PCSrcE,
  output logic [XLEN-1:0]       PCTargetE,
  output logic                  RegWriteM,
  output logic                  MemWriteM,
  output logic                  ResultSrcM,
  output logic [REG_ADDR_W-1:0] RD_M,
  output logic [XLEN-1:0]       ALUResultM,
  output logic [XLEN-1:0]       WriteDataM,
  output logic [XLEN-1:0]       PCPlus4M
);

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic            zero;

  // Select 2'b11 is unused by the hazard unit and falls back to the RF value.
  always_comb begin
    case (ForwardA_E)
      FWD_WB:  src_a = ResultW;
      FWD_MEM: src_a = ALUResultM;
      default: src_a = RD1_E;
    endcase
    case (ForwardB_E)
      FWD_WB:  fwd_b = ResultW;
      FWD_MEM: fwd_b = ALUResultM;
      default: fwd_b = RD2_E;
    endcase
  end

  assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;

  alu #(.XLEN(XLEN)) u_alu (
    .a           (src_a),
    .b           (src_b),
    .alu_control (ALUControlE),
    .result      (alu_result),
    .zero        (zero)
  );

  assign PCSrcE    = BranchE & zero;
  assign PCTargetE = PCE + Imm_Ext_E;

  // ---- E/M pipeline register ----
  // Store data is the forwarded rs2 value, never the immediate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 1'b0;
      RD_M       <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
    end else begin
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      RD_M       <= RD_E;
      ALUResultM <= alu_result;
      WriteDataM <= fwd_b;
      PCPlus4M   <= PCPlus4E;
    end
  end

endmodule

// File: tb/tb_execute_cycle.sv
module tb_execute_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

  execute_cycle dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .ResultW(ResultW), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw, alusrc, mw, rs, br;
    logic [2:0]  op;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rd;
    logic [31:0] pc, pc4;
    logic [1:0]  fa, fb;
    logic [31:0] resw;
  } vec_t;

  typedef struct {
    logic        rw, mw, rs;
    logic [4:0]  rd;
    logic [31:0] alu, wd, pc4;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_alum = 32'h0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_alu(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [32:0] diff;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd5: begin
        // signed less-than via sign bits and borrow of the unsigned subtract
        diff = {1'b0, a} - {1'b0, b};
        if (a[31] != b[31]) return {31'd0, a[31]};
        return {31'd0, diff[32]};
      end
`ifdef EXEC_EXT_ALU_EN
      3'd4: return a ^ b;
      3'd6: return a << b[4:0];
      3'd7: return a >> b[4:0];
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_fwd(input logic [1:0] s, input logic [31:0] rf,
                                        input logic [31:0] wb);
    if (s == 2'b01) return wb;
    if (s == 2'b10) return model_alum;
    return rf;
  endfunction

  function automatic vec_t blank();
    vec_t v;
    v.rw = 0; v.alusrc = 0; v.mw = 0; v.rs = 0; v.br = 0; v.op = 3'd0;
    v.rd1 = 0; v.rd2 = 0; v.imm = 0; v.rd = 0; v.pc = 0; v.pc4 = 4;
    v.fa = 0; v.fb = 0; v.resw = 0;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    RegWriteE = v.rw; ALUSrcE = v.alusrc; MemWriteE = v.mw; ResultSrcE = v.rs;
    BranchE = v.br; ALUControlE = v.op; RD1_E = v.rd1; RD2_E = v.rd2;
    Imm_Ext_E = v.imm; RD_E = v.rd; PCE = v.pc; PCPlus4E = v.pc4;
    ForwardA_E = v.fa; ForwardB_E = v.fb; ResultW = v.resw;
  endtask

  // Drive at negedge, check combinational branch outputs, then check the
  // registered outputs just after the next posedge.
  task automatic apply(input vec_t v);
    logic [31:0] a, fb, b, res;
    exp_t e, got;
    @(negedge clk);
    drive(v);
    #1;
    a   = m_fwd(v.fa, v.rd1, v.resw);
    fb  = m_fwd(v.fb, v.rd2, v.resw);
    b   = v.alusrc ? v.imm : fb;
    res = m_alu(v.op, a, b);
    check("pcsrc", {31'd0, PCSrcE}, {31'd0, v.br & (res == 32'h0)});
    check("pctarget", PCTargetE, v.pc + v.imm);
    e.rw = v.rw; e.mw = v.mw; e.rs = v.rs; e.rd = v.rd;
    e.alu = res; e.wd = fb; e.pc4 = v.pc4;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    model_alum = res;
    got = exp_q.pop_front();
    check("regwrite_m", {31'd0, RegWriteM}, {31'd0, got.rw});
    check("memwrite_m", {31'd0, MemWriteM}, {31'd0, got.mw});
    check("resultsrc_m", {31'd0, ResultSrcM}, {31'd0, got.rs});
    check("rd_m", {27'd0, RD_M}, {27'd0, got.rd});
    check("aluresult_m", ALUResultM, got.alu);
    check("writedata_m", WriteDataM, got.wd);
    check("pcplus4_m", PCPlus4M, got.pc4);
  endtask

  task automatic check_m_zero(input string tag);
    check({tag, "_rw"}, {31'd0, RegWriteM}, 32'd0);
    check({tag, "_mw"}, {31'd0, MemWriteM}, 32'd0);
    check({tag, "_rs"}, {31'd0, ResultSrcM}, 32'd0);
    check({tag, "_rd"}, {27'd0, RD_M}, 32'd0);
    check({tag, "_alu"}, ALUResultM, 32'd0);
    check({tag, "_wd"}, WriteDataM, 32'd0);
    check({tag, "_pc4"}, PCPlus4M, 32'd0);
  endtask

  initial begin
    vec_t v;
    rst = 1'b1;
    drive(blank());
    #1;
    check_m_zero("reset_init");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // R-type add
    v = blank(); v.rd1 = 5; v.rd2 = 7; v.rd = 1; v.rw = 1;
    apply(v);
    check("add_const", ALUResultM, 32'd12);
    check("add_rd", {27'd0, RD_M}, 32'd1);

    // beq taken and not taken
    v = blank(); v.rd1 = 32'hAABBCCDD; v.rd2 = 32'hAABBCCDD; v.op = 3'd1; v.br = 1;
    v.pc = 32'hC; v.imm = 32'h10;
    @(negedge clk); drive(v); #1;
    check("beq_taken", {31'd0, PCSrcE}, 32'd1);
    check("beq_target", PCTargetE, 32'h1C);
    apply(v);
    v.rd2 = 0;
    @(negedge clk); drive(v); #1;
    check("beq_not_taken", {31'd0, PCSrcE}, 32'd0);
    apply(v);

    // Forwarding from WB (A) and MEM (B)
    v = blank(); v.rd1 = 32'h18; v.rd2 = 32'h8; v.rd = 3; v.rw = 1;
    apply(v);
    check("fwd_setup", ALUResultM, 32'h20);
    v = blank(); v.rd1 = 32'h999; v.rd2 = 32'h777; v.fa = 2'b01; v.resw = 32'h10;
    v.fb = 2'b10; v.rd = 4; v.rw = 1;
    apply(v);
    check("fwd_result", ALUResultM, 32'h30);
    check("fwd_storedata", WriteDataM, 32'h20);

    // Store: immediate addressing, store data from RD2
    v = blank(); v.mw = 1; v.alusrc = 1; v.rd1 = 32'h100; v.imm = 32'hC;
    v.rd2 = 32'hDEADBEEF; v.pc4 = 32'h44;
    apply(v);
    check("store_addr", ALUResultM, 32'h10C);
    check("store_data", WriteDataM, 32'hDEADBEEF);
    check("store_mw", {31'd0, MemWriteM}, 32'd1);

    // slt signed
    v = blank(); v.rd1 = 32'hFFFFFFFF; v.rd2 = 1; v.op = 3'd5;
    apply(v);
    check("slt_neg", ALUResultM, 32'd1);
    v.rd1 = 1; v.rd2 = 32'hFFFFFFFF;
    apply(v);
    check("slt_pos", ALUResultM, 32'd0);

    // Optional op: shift left
    v = blank(); v.rd1 = 1; v.rd2 = 4; v.op = 3'd6;
    apply(v);
`ifdef EXEC_EXT_ALU_EN
    check("sll", ALUResultM, 32'h10);
`else
    check("sll_disabled", ALUResultM, 32'h0);
`endif

    // Select 2'b11 behaves like the register file path
    v = blank(); v.rd1 = 32'h40; v.rd2 = 32'h2; v.fa = 2'b11; v.fb = 2'b11;
    v.resw = 32'h5555; v.op = 3'd3;
    apply(v);
    check("fwd11", ALUResultM, 32'h42);

    // Random mix of ops, selects and controls
    for (int i = 0; i < 24; i++) begin
      v.rw = 1'($urandom); v.alusrc = 1'($urandom); v.mw = 1'($urandom);
      v.rs = 1'($urandom); v.br = 1'($urandom); v.op = 3'($urandom);
      v.rd1 = $urandom; v.rd2 = (i % 4 == 0) ? v.rd1 : $urandom; v.imm = $urandom;
      v.rd = 5'($urandom); v.pc = $urandom; v.pc4 = v.pc + 4;
      v.fa = 2'($urandom); v.fb = 2'($urandom); v.resw = $urandom;
      apply(v);
    end

    // Asynchronous reset in the middle of a cycle
    v = blank(); v.rd1 = 32'h11; v.rd2 = 32'h22; v.rw = 1; v.rd = 9; v.pc4 = 32'h80;
    apply(v);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_m_zero("reset_async");
    // ALUResultM forwarded during reset is 0, so a beq against 0 is taken
    v = blank(); v.fa = 2'b10; v.rd1 = 32'h1234; v.rd2 = 0; v.op = 3'd1; v.br = 1;
    drive(v);
    #1;
    check("reset_fwd_mem", {31'd0, PCSrcE}, 32'd1);
    model_alum = 32'h0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check_m_zero("reset_hold");
    rst = 1'b0;
    v = blank(); v.rd1 = 32'h3; v.rd2 = 32'h4; v.rw = 1; v.rd = 7; v.pc4 = 32'h24;
    apply(v);
    check("post_reset", ALUResultM, 32'h7);
    check("post_reset_rd", {27'd0, RD_M}, 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
